aes_lockstep_monitor: RTL
=========================

// Module: aes_lockstep_monitor
// PURPOSE
//  Parametrised runtime monitor for the AES trust test harness. Observes a DUT AES core and a
//  golden AES core fed identical state/key in lockstep, realigns a valid tag through the fixed
//  core latency, compares the ciphertexts, and counts samples and mismatches. A sticky alarm is
//  raised once mismatches reach a threshold. Sits in the harness top beside the AES instances.
// PARAMETERS
//  DATA_W   128  ciphertext width compared
//  LAT      20   AES core latency in cycles, in_valid to result (>=1)
//  CNT_W    16   width of sample/mismatch counters (saturating)
//  THRESH   1    mismatches needed to enter ALARM (>=1)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  enable       in   1        1 = accept new in_valid samples
//  clear        in   1        sync clear: counters, first_diff, alarm, pipeline
//  in_valid     in   1        state/key presented to both cores this cycle
//  dut_out      in   DATA_W   DUT core result
//  gold_out     in   DATA_W   golden core result
//  out_valid    out  1        aligned valid: dut_out/gold_out are the result of an accepted sample
//  mismatch     out  1        one-cycle pulse, registered compare failure
//  alarm        out  1        sticky, high in ALARM state
//  status       out  2        FSM state: 0 IDLE, 1 RUN, 2 ALARM
//  sample_cnt   out  CNT_W    compared samples, saturating
//  mismatch_cnt out  CNT_W    failed samples, saturating
//  first_diff   out  DATA_W   dut_out^gold_out of first mismatch since reset/clear
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, valid pipeline 0, status=IDLE.
//  - Accept: acc = in_valid & enable & (status!=IDLE or enable). Accepted sample at cycle t ->
//    out_valid high at t+LAT (LAT-stage shift register, combinational tap on last stage).
//  - Compare at out_valid: diff = dut_out^gold_out. Registered: at t+LAT+1 sample_cnt+1;
//    if diff!=0 also mismatch=1 (one cycle), mismatch_cnt+1, and first_diff=diff if
//    mismatch_cnt was 0. Counters stick at 2^CNT_W-1.
//  - Back-to-back accepts each cycle are all compared; no gaps required.
//  - enable=0 blocks new accepts only; in-flight samples still compare and count.
//  - FSM: IDLE -> RUN when enable=1. RUN -> IDLE when enable=0 and pipeline empty.
//    RUN -> ALARM on the cycle mismatch_cnt reaches THRESH (same edge as the count).
//    ALARM is sticky against enable; only clear or rst leaves it.
//  - clear=1: pipeline, counters, first_diff, mismatch, alarm zeroed next edge; status -> RUN
//    if enable else IDLE. clear beats a simultaneous out_valid compare (sample dropped) and a
//    simultaneous accept (not launched).
//  - Reset mid-operation: in-flight samples discarded, no late mismatch pulse.
//  - alarm == (status==ALARM), registered; no combinational path from inputs to alarm.
// STRUCTURE
//  - Shared package: status encodings (ST_IDLE/ST_RUN/ST_ALARM), default AES latency constant
//    (AES128_LAT=20), reused by harness tops and benches.
//  - One sub-module: valid_delay_line (LAT-deep 1-bit shift register, async active-low reset,
//    sync clear); the rest (compare, counters, FSM) stays flat in this module.
// TESTING
//  1 Reset: rst=0 mid-stream -> all outputs 0, status=0; after release no stale out_valid.
//  2 Match: enable=1, 5 accepts back-to-back, gold=dut=0x69c4e0d86a7b0430d8cdb78070b4c55a
//    -> out_valid at t+20..t+24, sample_cnt=5, mismatch_cnt=0, mismatch never high, alarm=0.
//  3 Mismatch, THRESH=1: flip dut bit 0 on 3rd sample -> mismatch pulse at t+23,
//    first_diff=128'h1, mismatch_cnt=1, status=2, alarm=1 and stays after enable=0.
//  4 THRESH=3, diffs 0x1, 0x2, 0x4 on samples 1,2,4 -> first_diff=0x1, alarm only after 4th
//    compare, mismatch_cnt=3, sample_cnt=4.
//  5 Clear collision: clear on same cycle as out_valid of a mismatching sample -> counters 0,
//    no mismatch pulse, status=1 with enable=1; alarm cleared.
//  6 Saturation, CNT_W=4: 20 mismatching samples -> both counters hold 15, no wrap; enable=0
//    with 3 in flight -> those 3 still compared, then status=2 remains (ALARM).

Source files
------------

// File: rtl/aes_lockstep_monitor_pkg.sv
// Shared definitions for the AES lockstep harness: monitor status encodings and core latency.
package aes_lockstep_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALARM = 2'd2
  } status_e;

  localparam int AES128_LAT = 20;

endpackage

// File: rtl/aes_lockstep_monitor_valid_delay_line.sv
// LAT-deep 1-bit shift register carrying the accepted-sample tag alongside the AES cores.
module valid_delay_line #(
  parameter int LAT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic din,
  output logic dout,
  output logic busy
);

  logic [LAT-1:0] stage;

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    logic stage_in;
    logic q;

    if (gi == 0) begin : g_head
      assign stage_in = din;
    end else begin : g_tail
      assign stage_in = stage[gi-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q <= 1'b0;
      end else if (clear) begin
        q <= 1'b0;
      end else begin
        q <= stage_in;
      end
    end

    assign stage[gi] = q;
  end

  // Last stage is tapped directly so out_valid lines up with the core result cycle.
  assign dout = stage[LAT-1];
  assign busy = |stage;

endmodule

// File: rtl/aes_lockstep_monitor.sv
// Lockstep monitor: realigns the sample tag through the core latency, compares DUT vs golden
// ciphertext, keeps saturating counters and raises a sticky alarm at the mismatch threshold.
module aes_lockstep_monitor
  import aes_lockstep_monitor_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int LAT    = AES128_LAT,
  parameter int CNT_W  = 16,
  parameter int THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] dut_out,
  input  logic [DATA_W-1:0] gold_out,
  output logic              out_valid,
  output logic              mismatch,
  output logic              alarm,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [DATA_W-1:0] first_diff
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(THRESH);

  status_e           state;
  logic              accept;
  logic              pipe_busy;
  logic              diff_event;
  logic              reach_alarm;
  logic [DATA_W-1:0] diff;
  logic [CNT_W-1:0]  mismatch_cnt_next;

  // A simultaneous clear wins over a new accept.
  assign accept = in_valid & enable & ~clear;

  valid_delay_line #(
    .LAT(LAT)
  ) u_valid_delay_line (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .din  (accept),
    .dout (out_valid),
    .busy (pipe_busy)
  );

  assign diff       = dut_out ^ gold_out;
  assign diff_event = out_valid & (|diff);

  always_comb begin
    mismatch_cnt_next = mismatch_cnt;
    if (diff_event && (mismatch_cnt != CNT_MAX)) begin
      mismatch_cnt_next = mismatch_cnt + CNT_W'(1);
    end
  end

  // Alarm entry uses the post-increment count so it lands on the same edge as the count.
  assign reach_alarm = diff_event && (mismatch_cnt_next >= THRESH_CNT);
  assign status      = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      alarm        <= 1'b0;
      mismatch     <= 1'b0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      first_diff   <= '0;
    end else if (clear) begin
      state        <= enable ? ST_RUN : ST_IDLE;
      alarm        <= 1'b0;
      mismatch     <= 1'b0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      first_diff   <= '0;
    end else begin
      mismatch     <= diff_event;
      mismatch_cnt <= mismatch_cnt_next;
      if (out_valid && (sample_cnt != CNT_MAX)) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if (diff_event && (mismatch_cnt == '0)) begin
        first_diff <= diff;
      end
      case (state)
        ST_IDLE: begin
          if (reach_alarm) begin
            state <= ST_ALARM;
            alarm <= 1'b1;
          end else if (enable) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (reach_alarm) begin
            state <= ST_ALARM;
            alarm <= 1'b1;
          end else if (!enable && !pipe_busy) begin
            state <= ST_IDLE;
          end
        end
        ST_ALARM: begin
          state <= ST_ALARM;
          alarm <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule
